// File: rtl/mips_mem_pkg.sv
// Shared types and helpers for the load/store unit: access modes, FSM states,
// and the mode decode / alignment rules used at request acceptance.
package mips_mem_pkg;

    localparam int DATA_WIDTH = 32;

    typedef enum logic [1:0] {
        WORD = 2'b00,
        HALF = 2'b10,
        BYTE = 2'b11
    } mem_mode_t;

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        ISSUE   = 2'b01,
        CAPTURE = 2'b10,
        RESP    = 2'b11
    } lsu_state_t;

    // The unused encoding 01 behaves as a word access.
    function automatic mem_mode_t decode_mode(input logic [1:0] raw);
        case (raw)
            2'b10:   return HALF;
            2'b11:   return BYTE;
            default: return WORD;
        endcase
    endfunction

    function automatic logic is_misaligned(input mem_mode_t mode, input logic [1:0] addr_lo);
        case (mode)
            WORD:    return addr_lo != 2'b00;
            HALF:    return addr_lo[0];
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [1:0] align_low(input mem_mode_t mode, input logic [1:0] addr_lo);
        case (mode)
            WORD:    return 2'b00;
            HALF:    return {addr_lo[1], 1'b0};
            default: return addr_lo;
        endcase
    endfunction

endpackage

// File: rtl/load_extend.sv
// Picks the addressed byte/half lane out of a memory read word and sign- or
// zero-extends it to 32 bits; words pass through untouched.
module load_extend
    import mips_mem_pkg::*;
(
    input  logic [DATA_WIDTH-1:0] word_i,
    input  logic [1:0]            addr_lo_i,
    input  mem_mode_t             mode_i,
    input  logic                  unsigned_i,
    output logic [DATA_WIDTH-1:0] result_o
);

    logic [7:0]  byte_lane;
    logic [15:0] half_lane;

    always_comb begin
        byte_lane = word_i[7:0];
        case (addr_lo_i)
            2'd0:    byte_lane = word_i[7:0];
            2'd1:    byte_lane = word_i[15:8];
            2'd2:    byte_lane = word_i[23:16];
            default: byte_lane = word_i[31:24];
        endcase
        half_lane = addr_lo_i[1] ? word_i[31:16] : word_i[15:0];

        result_o = word_i;
        case (mode_i)
            BYTE:    result_o = {{24{byte_lane[7] & ~unsigned_i}}, byte_lane};
            HALF:    result_o = {{16{half_lane[15] & ~unsigned_i}}, half_lane};
            default: result_o = word_i;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Single-outstanding load/store unit in front of a registered-read data memory.
// Define LSU_MISALIGN_TRAP_EN to reject misaligned accesses with an error
// response; otherwise addresses are silently forced to alignment.
module load_store_unit
    import mips_mem_pkg::*;
#(
    parameter int ADDRESS_WIDTH = 8
) (
    input  logic                     clock_in,
    input  logic                     reset_n_in,
    input  logic                     req_valid_in,
    output logic                     req_ready_out,
    input  logic                     req_write_in,
    input  logic [1:0]               req_mode_in,
    input  logic                     req_unsigned_in,
    input  logic [ADDRESS_WIDTH-1:0] req_address_in,
    input  logic [DATA_WIDTH-1:0]    req_write_data_in,
    output logic                     resp_valid_out,
    input  logic                     resp_ready_in,
    output logic [DATA_WIDTH-1:0]    resp_data_out,
    output logic                     resp_error_out,
    output logic                     mem_write_out,
    output logic [1:0]               mem_mode_out,
    output logic [ADDRESS_WIDTH-1:0] mem_address_out,
    output logic [DATA_WIDTH-1:0]    mem_write_data_out,
    input  logic [DATA_WIDTH-1:0]    mem_read_data_in,
    output lsu_state_t               state_dbg_out
);

    // Handshakes: a transfer happens on a rising edge where valid and ready are
    // both high; valid never waits on ready and response fields hold while
    // resp_valid_out is high and resp_ready_in is low.

    lsu_state_t             state_q, state_d;
    logic                   write_q;
    logic                   unsigned_q;
    mem_mode_t              mem_mode_q;
    logic [ADDRESS_WIDTH-1:0] mem_addr_q;
    logic [DATA_WIDTH-1:0]  mem_wdata_q;
    logic [DATA_WIDTH-1:0]  resp_data_q;
    logic                   resp_error_q;

    mem_mode_t              req_mode;
    logic                   req_misaligned;
    logic [ADDRESS_WIDTH-1:0] req_addr_eff;
    logic                   accept;
    logic [DATA_WIDTH-1:0]  load_value;

    always_comb begin
        req_mode = decode_mode(req_mode_in);
`ifdef LSU_MISALIGN_TRAP_EN
        req_misaligned = is_misaligned(req_mode, req_address_in[1:0]);
        req_addr_eff   = req_address_in;
`else
        req_misaligned = 1'b0;
        req_addr_eff   = {req_address_in[ADDRESS_WIDTH-1:2], align_low(req_mode, req_address_in[1:0])};
`endif
        accept = (state_q == IDLE) && req_valid_in;
    end

    always_ff @(posedge clock_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (req_valid_in) state_d = req_misaligned ? RESP : ISSUE;
            ISSUE:   state_d = write_q ? RESP : CAPTURE;
            CAPTURE: state_d = RESP;
            RESP:    if (resp_ready_in) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // mem_write_out decodes straight from state so reset kills it without waiting for an edge.
    always_comb begin
        req_ready_out  = (state_q == IDLE);
        resp_valid_out = (state_q == RESP);
        mem_write_out  = (state_q == ISSUE) && write_q;
    end

    // Memory-side registers load only for requests that will issue, so they
    // keep the previous access's values outside ISSUE.
    always_ff @(posedge clock_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            write_q      <= 1'b0;
            unsigned_q   <= 1'b0;
            mem_mode_q   <= WORD;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            resp_data_q  <= '0;
            resp_error_q <= 1'b0;
        end else if (accept) begin
            write_q      <= req_write_in;
            unsigned_q   <= req_unsigned_in;
            resp_data_q  <= '0;
            resp_error_q <= req_misaligned;
            if (!req_misaligned) begin
                mem_mode_q  <= req_mode;
                mem_addr_q  <= req_addr_eff;
                mem_wdata_q <= req_write_data_in;
            end
        end else if (state_q == CAPTURE) begin
            resp_data_q <= load_value;
        end
    end

    load_extend u_load_extend (
        .word_i     (mem_read_data_in),
        .addr_lo_i  (mem_addr_q[1:0]),
        .mode_i     (mem_mode_q),
        .unsigned_i (unsigned_q),
        .result_o   (load_value)
    );

    assign resp_data_out      = resp_data_q;
    assign resp_error_out     = resp_error_q;
    assign mem_mode_out       = mem_mode_q;
    assign mem_address_out    = mem_addr_q;
    assign mem_write_data_out = mem_wdata_q;
    assign state_dbg_out      = state_q;

endmodule
